uart_rsp_encoder: RTL and testbench

UART_RSP_ENCODER -- requirements
Module: uart_rsp_encoder

---
 rtl/uart_rsp_encoder.sv | 153 +++++++++++++++
 tb/tb_uart_rsp_encoder.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rsp_encoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_rsp_encoder                                                           |
// | Buffers 34-bit bus responses and streams each one as a 5-byte UART frame.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module uart_rsp_encoder #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_rsp_stb,
  input  logic [33:0] i_rsp_word,
  output logic        o_busy,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_stb,
  input  logic        i_tx_busy,
  output logic        o_ovf,
  input  logic        i_ovf_clr
);

  localparam int                 c_PTR_W     = $clog2(FIFO_DEPTH);
  localparam int                 c_CNT_W     = c_PTR_W + 1;
  localparam logic [c_CNT_W-1:0] c_FULL      = c_CNT_W'(FIFO_DEPTH);
  localparam logic [7:0]         c_HDR_BASE  = 8'hA0;
  localparam logic [2:0]         c_LAST_BYTE = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2,
    ST_WAIT = 2'd3
  } state_t;

  logic [33:0]        r_mem [FIFO_DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_CNT_W-1:0] r_count;
  logic               r_ovf;
  state_t             r_state;
  logic [39:0]        r_frame;
  logic [2:0]         r_byte_cnt;
  logic               r_tx_stb;

  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;
  logic [33:0]        w_head;
  logic [39:0]        w_frame;

  assign w_full  = (r_count == c_FULL);
  assign w_empty = (r_count == '0);
  assign w_push  = i_rsp_stb && !w_full;
  // LOAD is only ever entered with the FIFO non-empty, so it always pops.
  assign w_pop   = (r_state == ST_LOAD);
  assign w_head  = r_mem[r_rd_ptr];
  assign w_frame = {c_HDR_BASE | {6'b0, w_head[33:32]}, w_head[31:0]};

  assign o_busy    = w_full;
  assign o_ovf     = r_ovf;
  assign o_tx_stb  = r_tx_stb;
  // The frame register only shifts on entry to SEND, so its top byte is the
  // registered transmit byte.
  assign o_tx_data = r_frame[39:32];

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_rsp_word;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_W'(1);
        2'b01:   r_count <= r_count - c_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // A new overflow wins over a coincident clear.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_ovf <= 1'b0;
    end else if (i_rsp_stb && w_full) begin
      r_ovf <= 1'b1;
    end else if (i_ovf_clr) begin
      r_ovf <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state    <= ST_IDLE;
      r_frame    <= '0;
      r_byte_cnt <= '0;
      r_tx_stb   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_tx_stb <= 1'b0;
          if (!w_empty) begin
            r_state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          r_frame    <= w_frame;
          r_byte_cnt <= '0;
          r_tx_stb   <= 1'b1;
          r_state    <= ST_SEND;
        end
        ST_SEND: begin
          if (!i_tx_busy) begin
            r_tx_stb <= 1'b0;
            r_state  <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (!i_tx_busy) begin
            if (r_byte_cnt != c_LAST_BYTE) begin
              r_byte_cnt <= r_byte_cnt + 3'd1;
              r_frame    <= {r_frame[31:0], 8'h00};
              r_tx_stb   <= 1'b1;
              r_state    <= ST_SEND;
            end else if (!w_empty) begin
              r_state <= ST_LOAD;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        default: begin
          r_tx_stb <= 1'b0;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rsp_encoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_uart_rsp_encoder                                                        |
// | Scoreboard bench: expected byte stream built from the framing rules.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_uart_rsp_encoder;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rsp_stb = 1'b0;
  logic [33:0] rsp_word = '0;
  logic        o_busy;
  logic [7:0]  o_tx_data;
  logic        o_tx_stb;
  logic        tx_busy = 1'b0;
  logic        o_ovf;
  logic        ovf_clr = 1'b0;

  uart_rsp_encoder #(.FIFO_DEPTH(DEPTH)) dut (
    .i_clk      (clk),
    .i_reset_n  (rst_n),
    .i_rsp_stb  (rsp_stb),
    .i_rsp_word (rsp_word),
    .o_busy     (o_busy),
    .o_tx_data  (o_tx_data),
    .o_tx_stb   (o_tx_stb),
    .i_tx_busy  (tx_busy),
    .o_ovf      (o_ovf),
    .i_ovf_clr  (ovf_clr)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [7:0]  exp_q[$];
  logic [7:0]  log_q[$];
  int          m_count = 0;
  bit          m_ovf = 1'b0;
  int          m_idx = 0;
  bit          prev_stb = 1'b0;
  bit          prev_txb = 1'b0;
  logic [7:0]  prev_data = '0;
  logic [39:0] m_frame;
  bit          m_full;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor/model: runs mid-low-phase, when inputs for the next edge are settled.
  always @(negedge clk) begin
    #3;
    if (!rst_n) begin
      check("rst_tx_stb", o_tx_stb, 0);
      check("rst_tx_data", o_tx_data, 0);
      check("rst_busy", o_busy, 0);
      check("rst_ovf", o_ovf, 0);
      exp_q.delete();
      m_count  = 0;
      m_ovf    = 1'b0;
      m_idx    = 0;
      prev_stb = 1'b0;
      prev_txb = 1'b0;
    end else begin
      // A new frame appearing means its word left the FIFO on the last edge.
      if (o_tx_stb && !prev_stb && m_idx == 0 && m_count > 0) m_count--;
      if (o_tx_stb && exp_q.size() == 0) check("spurious_stb", o_tx_stb, 0);
      if (prev_stb && prev_txb) begin
        check("hold_stb", o_tx_stb, 1);
        check("hold_data", o_tx_data, prev_data);
      end
      check("busy", o_busy, (m_count == DEPTH));
      check("ovf", o_ovf, m_ovf);
      if (o_tx_stb && !tx_busy && exp_q.size() > 0) begin
        check("byte", o_tx_data, exp_q.pop_front());
        log_q.push_back(o_tx_data);
        m_idx = (m_idx + 1) % 5;
      end
      m_full = (m_count == DEPTH);
      if (rsp_stb) begin
        if (m_full) begin
          m_ovf = 1'b1;
        end else begin
          m_count++;
          m_frame = {8'hA0 | {6'd0, rsp_word[33:32]}, rsp_word[31:0]};
          for (int k = 0; k < 5; k++) exp_q.push_back(m_frame[39-8*k -: 8]);
        end
      end
      if (ovf_clr && !(rsp_stb && m_full)) m_ovf = 1'b0;
      prev_stb  = o_tx_stb;
      prev_txb  = tx_busy;
      prev_data = o_tx_data;
    end
  end

  task automatic push(input logic [33:0] w);
    rsp_stb  = 1'b1;
    rsp_word = w;
    @(posedge clk); #1;
    rsp_stb  = 1'b0;
  endtask

  task automatic wait_tx(input int idx, input string name);
    int n = 0;
    while (!(o_tx_stb && m_idx == idx) && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    if (n >= 200) begin
      tests++; fails++;
      $display("FAIL %s: timeout waiting for byte %0d, actual stb %0b", name, idx, o_tx_stb);
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    tx_busy = 1'b0;
    rsp_stb = 1'b0;
    ovf_clr = 1'b0;
    while ((exp_q.size() > 0 || o_tx_stb) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      tests++; fails++;
      $display("FAIL %s: drain timeout, actual %0d bytes pending required 0", name, exp_q.size());
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog");
  end

  logic [7:0] beef [5];
  int         n_stb;

  initial begin
    beef = '{8'hA2, 8'hDE, 8'hAD, 8'hBE, 8'hEF};

    // Reset values, then push on the first edge after release.
    repeat (2) @(negedge clk);
    #1;
    check("init_stb", o_tx_stb, 0);
    check("init_data", o_tx_data, 0);
    check("init_busy", o_busy, 0);
    check("init_ovf", o_ovf, 0);
    @(posedge clk); #1;
    log_q.delete();
    rst_n    = 1'b1;
    rsp_stb  = 1'b1;
    rsp_word = 34'h2_DEADBEEF;
    @(posedge clk); #1;
    rsp_stb = 1'b0;
    @(negedge clk); check("lat_edge0", o_tx_stb, 0);
    @(negedge clk); check("lat_edge1", o_tx_stb, 0);
    @(negedge clk); check("lat_edge2", o_tx_stb, 1);
    check("lat_hdr", o_tx_data, 8'hA2);
    @(posedge clk); #1;
    drain("single");
    check("single_len", log_q.size(), 5);
    for (int i = 0; i < 5 && i < log_q.size(); i++) check("single_byte", log_q[i], beef[i]);

    // Transmitter stall on byte 2.
    log_q.delete();
    push(34'h0_11AD2233);
    wait_tx(2, "stall_wait");
    tx_busy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_stb", o_tx_stb, 1);
      check("stall_data", o_tx_data, 8'hAD);
    end
    #1;
    tx_busy = 1'b0;
    @(posedge clk); #1;
    drain("stall");
    check("stall_len", log_q.size(), 5);
    if (log_q.size() == 5) check("stall_next", log_q[3], 8'h22);

    // Overflow with the transmitter stalled on an in-flight frame.
    log_q.delete();
    tx_busy = 1'b1;
    push({2'($urandom), 32'($urandom)});
    wait_tx(0, "ovf_wait");
    @(posedge clk); #1;
    for (int i = 1; i <= 5; i++) begin
      rsp_stb  = 1'b1;
      rsp_word = {2'($urandom), 32'($urandom)};
      @(posedge clk); #1;
      if (i == 3) check("busy_before_full", o_busy, 0);
      if (i == 4) check("busy_full", o_busy, 1);
      if (i == 5) check("ovf_set", o_ovf, 1);
    end
    rsp_word = {2'($urandom), 32'($urandom)};
    ovf_clr  = 1'b1;
    @(posedge clk); #1;
    check("ovf_clr_collide", o_ovf, 1);
    rsp_stb = 1'b0;
    @(posedge clk); #1;
    check("ovf_clr", o_ovf, 0);
    ovf_clr = 1'b0;
    drain("ovf");
    check("ovf_frames", log_q.size(), 25);

    // Reset in the middle of a frame with two more words queued.
    log_q.delete();
    tx_busy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rsp_stb  = 1'b1;
      rsp_word = {2'($urandom), 32'($urandom)};
      @(posedge clk); #1;
    end
    rsp_stb = 1'b0;
    wait_tx(3, "rst_wait");
    rst_n = 1'b0;
    #1;
    check("arst_stb", o_tx_stb, 0);
    check("arst_data", o_tx_data, 0);
    check("arst_busy", o_busy, 0);
    check("arst_ovf", o_ovf, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    n_stb = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (o_tx_stb) n_stb++;
    end
    check("post_rst_silent", n_stb, 0);
    @(posedge clk); #1;

    // Random traffic: pointer wrap, back-to-back frames, occasional drops.
    for (int i = 0; i < 800; i++) begin
      rsp_stb  = ($urandom_range(0, 2) == 0) && (!o_busy || $urandom_range(0, 7) == 0);
      rsp_word = {2'($urandom), 32'($urandom)};
      tx_busy  = ($urandom_range(0, 3) == 0);
      ovf_clr  = ($urandom_range(0, 15) == 0);
      @(posedge clk); #1;
    end
    drain("random");
    check("final_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
